param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 16: number of storage words, legal range 2..1024, power of two not required.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: fifo_almost_full asserts when occupancy is at least AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: fifo_almost_empty asserts when occupancy is at most AE_LEVEL.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port fifo_write, input, 1 bit: write request.
REQ-008 Port fifo_read, input, 1 bit: read request.
REQ-009 Port fifo_data_in, input, WIDTH bits: write data.
REQ-010 Port fifo_data_out, output, WIDTH bits: registered read data.
REQ-011 Port fifo_full / fifo_empty, output, 1 bit each: occupancy equals DEPTH / occupancy equals 0.
REQ-012 Port fifo_almost_full / fifo_almost_empty, output, 1 bit each: threshold flags.
REQ-013 Port fifo_count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 Port fifo_overflow / fifo_underflow, output, 1 bit each: sticky error flags; these ports exist only when FIFO_ERR_FLAGS_EN is defined.

Function
REQ-015 Write accepted = fifo_write & (!fifo_full | read accepted); read accepted = fifo_read & !fifo_empty.
REQ-016 Simultaneous accepted read and write in one cycle: both pointers advance and fifo_count is unchanged.
REQ-017 Full with read+write requested: the write is accepted because the read frees a slot; count stays DEPTH.
REQ-018 Empty with read+write requested: only the write is accepted, and count becomes 1 (no fall-through).
REQ-019 An accepted write stores fifo_data_in at wr_ptr on the same edge.
REQ-020 An accepted read loads mem[rd_ptr] into fifo_data_out on the same edge; data are visible one cycle after the request, and fifo_data_out holds its value otherwise.
REQ-021 Each pointer is $clog2(DEPTH) bits and wraps from DEPTH-1 to 0 by explicit compare, for any DEPTH.
REQ-022 fifo_count increments on write-only, decrements on read-only, and never exceeds DEPTH or goes below 0.
REQ-023 All flags are combinational decodes of the registered fifo_count.
REQ-024 Rejected requests (write while full without a read, read while empty) change no state other than the error flags.

Reset
REQ-025 rst low asynchronously clears wr_ptr, rd_ptr, fifo_count and fifo_data_out to 0, and clears the error flags.
REQ-026 During reset: fifo_empty=1, fifo_full=0, fifo_almost_empty=1, and fifo_almost_full=0 (given AF_LEVEL>0).
REQ-027 Storage contents are not reset; data written before a mid-operation reset are unreachable afterwards.
REQ-028 Requests asserted while rst is low are ignored; the first accepted operation occurs at the first rising edge with rst high.

Configuration
REQ-029 With macro FIFO_ERR_FLAGS_EN defined: fifo_overflow sets on a rejected write and fifo_underflow sets on a rejected read; both clear only on reset.
REQ-030 Without FIFO_ERR_FLAGS_EN: the ports and error logic are absent, and rejected requests are silently dropped.

Structure
REQ-031 Package fifo_pkg contains the default constants and a count-width helper function; ptr_t and cnt_t are derived from DEPTH inside the module.
REQ-032 Storage is a sub-module fifo_mem (WIDTH x DEPTH register array, one write port, one registered read port); param_fifo holds the pointers, count, flags and control.
REQ-033 An elaboration-time check fails when AE_LEVEL >= AF_LEVEL or AF_LEVEL > DEPTH.

Verification
REQ-034 Reset, then write 0x0001..0x0010 (DEPTH=16) -> fifo_full=1 and fifo_count=16; reading 16 times returns 0x0001..0x0010 in order, each one cycle after its read.
REQ-035 Full FIFO, read+write of 0xBEEF in one cycle -> count stays 16, and 0xBEEF is the 16th word read after the 15 older words.
REQ-036 Empty FIFO, read+write of 0x1234 -> count=1, fifo_data_out unchanged; the next read returns 0x1234.
REQ-037 Write 3 words, read 3, then repeat 10 times -> pointers wrap past 15 with no data corruption; fifo_almost_empty toggles at count 2 and 3.
REQ-038 With FIFO_ERR_FLAGS_EN: write while full -> fifo_overflow=1 and sticky; read while empty -> fifo_underflow=1; both clear on rst.
REQ-039 Assert rst mid-burst at count=7 -> all outputs take reset values immediately, without waiting for a clock edge; a subsequent write/read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for param_fifo and its storage sub-module.
package fifo_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AE_LEVEL = 2;

    // Occupancy has DEPTH+1 distinct values (0..DEPTH).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array with one write port and one registered read port.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: pointers, occupancy count and flags around a fifo_mem array.
// Define FIFO_ERR_FLAGS_EN to add sticky fifo_overflow / fifo_underflow outputs.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fifo_write,
    input  logic                          fifo_read,
    input  logic [WIDTH-1:0]              fifo_data_in,
    output logic [WIDTH-1:0]              fifo_data_out,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          fifo_almost_full,
    output logic                          fifo_almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   fifo_count
`ifdef FIFO_ERR_FLAGS_EN
   ,output logic                          fifo_overflow,
    output logic                          fifo_underflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_AF   = cnt_t'(AF_LEVEL);
    localparam cnt_t CNT_AE   = cnt_t'(AE_LEVEL);

    if (AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_cfg_err
        $error("param_fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic full, empty;
    logic wr_acc, rd_acc;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign rd_acc = fifo_read & ~empty;
    // A read in the same cycle frees a slot, so a full FIFO can still take a write.
    assign wr_acc = fifo_write & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ptr_t'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ptr_t'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + cnt_t'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (fifo_data_out)
    );

    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (count_q >= CNT_AF);
    assign fifo_almost_empty = (count_q <= CNT_AE);
    assign fifo_count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign ovf_d = ovf_q | (fifo_write & ~wr_acc);
    assign unf_d = unf_q | (fifo_read & ~rd_acc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = unf_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed, table-driven bench for param_fifo at its default 16 x 16 configuration.
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_write = 1'b0;
    logic        fifo_read = 1'b0;
    logic [15:0] fifo_data_in = '0;
    logic [15:0] fifo_data_out;
    logic        fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [4:0]  fifo_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic        fifo_overflow, fifo_underflow;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    param_fifo dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_write        (fifo_write),
        .fifo_read         (fifo_read),
        .fifo_data_in      (fifo_data_in),
        .fifo_data_out     (fifo_data_out),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_count        (fifo_count)
`ifdef FIFO_ERR_FLAGS_EN
       ,.fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
`endif
    );

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] din;
        int          cnt;
        logic [15:0] dout;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic chk_all(input int idx, input int cnt, input logic [15:0] dout,
                           input logic full, input logic empty, input logic af, input logic ae);
        chk("count", idx, 32'(fifo_count), 32'(cnt));
        chk("data_out", idx, 32'(fifo_data_out), 32'(dout));
        chk("full", idx, 32'(fifo_full), 32'(full));
        chk("empty", idx, 32'(fifo_empty), 32'(empty));
        chk("almost_full", idx, 32'(fifo_almost_full), 32'(af));
        chk("almost_empty", idx, 32'(fifo_almost_empty), 32'(ae));
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        fifo_write   = w;
        fifo_read    = r;
        fifo_data_in = d;
        @(posedge clk);
        #1;
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
    endtask

    task automatic add(input logic w, input logic r, input logic [15:0] din, input int cnt,
                       input logic [15:0] dout);
        vec_t v;
        v.w = w; v.r = r; v.din = din; v.cnt = cnt; v.dout = dout;
        v.full  = (cnt == 16);
        v.empty = (cnt == 0);
        v.af    = (cnt >= 14);
        v.ae    = (cnt <= 2);
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] last;

        // Fill 0x0001..0x0010, then drain in order.
        for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 16'(i + 1), i + 1, 16'h0000);
        for (int j = 0; j < 16; j++) add(1'b0, 1'b1, 16'h0000, 15 - j, 16'(j + 1));
        // Read+write on empty: only the write lands, output holds.
        add(1'b1, 1'b1, 16'h1234, 1, 16'h0010);
        add(1'b0, 1'b1, 16'h0000, 0, 16'h1234);
        // Three in, three out, ten times: pointers wrap several times.
        last = 16'h1234;
        for (int r = 0; r < 10; r++) begin
            for (int n = 0; n < 3; n++) add(1'b1, 1'b0, 16'(16'h0100 + r * 16 + n), n + 1, last);
            for (int n = 0; n < 3; n++) add(1'b0, 1'b1, 16'h0000, 2 - n, 16'(16'h0100 + r * 16 + n));
            last = 16'(16'h0100 + r * 16 + 2);
        end

        // Reset held with requests active: they must be ignored.
        rst          = 1'b0;
        fifo_write   = 1'b1;
        fifo_read    = 1'b1;
        fifo_data_in = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk_all(-1, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_rst", -1, 32'(fifo_overflow), 32'd0);
        chk("underflow_rst", -1, 32'(fifo_underflow), 32'd0);
`endif
        @(negedge clk);
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
        rst        = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].w, vecs[k].r, vecs[k].din);
            chk_all(k, vecs[k].cnt, vecs[k].dout, vecs[k].full, vecs[k].empty, vecs[k].af, vecs[k].ae);
        end

        // Full FIFO: rejected write, then read+write of 0xBEEF lands behind 15 older words.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'(16'hA000 + i));
        chk("full_count", 0, 32'(fifo_count), 32'd16);
        chk("full_flag", 0, 32'(fifo_full), 32'd1);
        step(1'b1, 1'b0, 16'hDEAD);
        chk("rejected_wr_count", 0, 32'(fifo_count), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_set", 0, 32'(fifo_overflow), 32'd1);
`endif
        step(1'b1, 1'b1, 16'hBEEF);
        chk("rw_full_count", 0, 32'(fifo_count), 32'd16);
        chk("rw_full_flag", 0, 32'(fifo_full), 32'd1);
        chk("rw_full_dout", 0, 32'(fifo_data_out), 32'hA000);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 16'h0000);
            chk("drain_dout", i, 32'(fifo_data_out), 32'(16'hA000 + i));
        end
        step(1'b0, 1'b1, 16'h0000);
        chk("beef_dout", 0, 32'(fifo_data_out), 32'hBEEF);
        chk("beef_empty", 0, 32'(fifo_empty), 32'd1);
        step(1'b0, 1'b1, 16'h0000);
        chk("rejected_rd_count", 0, 32'(fifo_count), 32'd0);
        chk("rejected_rd_dout", 0, 32'(fifo_data_out), 32'hBEEF);
`ifdef FIFO_ERR_FLAGS_EN
        chk("underflow_set", 0, 32'(fifo_underflow), 32'd1);
        chk("overflow_sticky", 0, 32'(fifo_overflow), 32'd1);
`endif

        // Asynchronous reset mid-burst at count 7.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'(16'h7000 + i));
        chk("burst_count", 0, 32'(fifo_count), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        chk_all(-2, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("overflow_clr", 0, 32'(fifo_overflow), 32'd0);
        chk("underflow_clr", 0, 32'(fifo_underflow), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 16'h5555);
        chk("post_rst_count", 0, 32'(fifo_count), 32'd1);
        step(1'b0, 1'b1, 16'h0000);
        chk("post_rst_dout", 0, 32'(fifo_data_out), 32'h5555);
        chk("post_rst_empty", 0, 32'(fifo_empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
